// File: rtl/inst_mem_loader_pkg.sv
// inst_mem_loader_pkg: shared loader states and constants.
package inst_mem_loader_pkg;
  typedef enum logic [2:0] {RUN, HDR, DATA, SUM, REL, ERR} state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int BCNT_W = 2;
endpackage

// File: rtl/inst_mem_loader_ld_word_asm.sv
// ld_word_asm: assembles 4 bytes LSB-first into a word; word_valid marks the 4th byte.
module ld_word_asm
  import inst_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [BCNT_W-1:0] cnt;
  logic [23:0] sh;
  assign word_valid = in_valid && &cnt;
  assign word = {data, sh};
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (in_valid) begin
      cnt <= cnt + BCNT_W'(1);
      sh <= {data, sh[23:8]};
    end
  end
endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: instruction memory fed by a byte-stream boot loader that holds the core in reset.
// Define LOADER_CHKSUM_EN to require a trailing 32-bit additive checksum on each image.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int ADDR_W = 12,
  parameter bit BOOT_HOLD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_o,
  input  logic        ld_start_i,
  input  logic        ld_valid_i,
  input  logic [7:0]  ld_data_i,
  output logic        ld_ready_o,
  output logic        core_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);
`ifdef LOADER_CHKSUM_EN
  localparam state_t LAST = SUM;
`else
  localparam state_t LAST = REL;
`endif
  state_t state;
  logic [31:0] mem [DEPTH];
  logic [31:0] n;
  logic [31:0] word;
  logic [ADDR_W:0] idx;
  logic accept;
  logic word_valid;
  logic unused_low;
  assign unused_low = ^inst_addr_i[1:0];
  assign ld_ready_o = state inside {HDR, DATA, SUM};
  // a byte arriving with a start pulse is consumed but discarded
  assign accept = ld_valid_i && ld_ready_o && !ld_start_i;
  assign inst_o = (state != RUN || |inst_addr_i[31:ADDR_W+2]) ? NOP : mem[inst_addr_i[ADDR_W+1:2]];
  ld_word_asm u_asm (
    .clk(clk),
    .rst(rst),
    .clr(ld_start_i),
    .in_valid(accept),
    .data(ld_data_i),
    .word_valid(word_valid),
    .word(word)
  );
  always_ff @(posedge clk) begin
    if (!rst && state == DATA && word_valid) mem[idx[ADDR_W-1:0]] <= word;
  end
`ifdef LOADER_CHKSUM_EN
  logic [31:0] sum;
  always_ff @(posedge clk) begin
    if (rst || state == HDR) sum <= '0;
    else if (state == DATA && word_valid) sum <= sum + word;
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT_HOLD ? HDR : RUN;
      core_rst_o <= BOOT_HOLD;
      busy_o <= BOOT_HOLD;
      done_o <= 1'b0;
      err_o <= 1'b0;
      n <= '0;
      idx <= '0;
    end else if (ld_start_i) begin
      state <= HDR;
      core_rst_o <= 1'b1;
      busy_o <= 1'b1;
      done_o <= 1'b0;
      err_o <= 1'b0;
      idx <= '0;
    end else begin
      case (state)
        HDR: if (word_valid) begin
          n <= word;
          idx <= '0;
          if (word == 32'd0 || word > 32'(DEPTH)) begin
            state <= ERR;
            err_o <= 1'b1;
            busy_o <= 1'b0;
          end else state <= DATA;
        end
        DATA: if (word_valid) begin
          idx <= idx + (ADDR_W+1)'(1);
          if (32'(idx) + 32'd1 == n) state <= LAST;
        end
`ifdef LOADER_CHKSUM_EN
        SUM: if (word_valid) begin
          if (word == sum) state <= REL;
          else begin
            state <= ERR;
            err_o <= 1'b1;
            busy_o <= 1'b0;
          end
        end
`endif
        REL: begin
          state <= RUN;
          core_rst_o <= 1'b0;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: scoreboard bench for the boot loader; stimulus queues expectations, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_inst_mem_loader;
  import inst_mem_loader_pkg::*;
  localparam int DEPTH = 4096;
  localparam int K_INST = 0, K_CRST = 1, K_BUSY = 2, K_DONE = 3, K_ERR = 4, K_RDY = 5;
  localparam int K_INST0 = 6, K_CRST0 = 7, K_BUSY0 = 8, K_ERR0 = 9, K_RDY0 = 10;
  typedef struct {
    string name;
    int kind;
    logic [31:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_addr0 = 32'h0001_0000;
  logic ld_start = 1'b0;
  logic ld_valid = 1'b0;
  logic [7:0] ld_data = '0;
  logic [31:0] inst, inst0;
  logic ld_ready, core_rst, busy, done, err;
  logic ld_ready0, core_rst0, busy0, done0, err0;
  exp_t q[$];
  exp_t e;
  logic [31:0] act;
  logic [31:0] img[$];
  int pass = 0;
  int total = 0;
  int tmo = 0;
  always #5 clk = ~clk;
  inst_mem_loader #(.DEPTH(DEPTH), .ADDR_W(12), .BOOT_HOLD(1'b1)) dut (
    .clk(clk), .rst(rst), .inst_addr_i(inst_addr), .inst_o(inst),
    .ld_start_i(ld_start), .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_ready_o(ld_ready),
    .core_rst_o(core_rst), .busy_o(busy), .done_o(done), .err_o(err)
  );
  inst_mem_loader #(.DEPTH(DEPTH), .ADDR_W(12), .BOOT_HOLD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .inst_addr_i(inst_addr0), .inst_o(inst0),
    .ld_start_i(1'b0), .ld_valid_i(1'b0), .ld_data_i(8'h00), .ld_ready_o(ld_ready0),
    .core_rst_o(core_rst0), .busy_o(busy0), .done_o(done0), .err_o(err0)
  );
  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        K_INST: act = inst;
        K_CRST: act = {31'b0, core_rst};
        K_BUSY: act = {31'b0, busy};
        K_DONE: act = {31'b0, done};
        K_ERR: act = {31'b0, err};
        K_RDY: act = {31'b0, ld_ready};
        K_INST0: act = inst0;
        K_CRST0: act = {31'b0, core_rst0};
        K_BUSY0: act = {31'b0, busy0};
        K_ERR0: act = {31'b0, err0 | done0};
        K_RDY0: act = {31'b0, ld_ready0};
        default: act = 'x;
      endcase
      total++;
      if (act === e.v) pass++;
      else $display("FAIL %s: got %h, expected %h", e.name, act, e.v);
    end
  end
  task automatic expect_v(input string nm, input int k, input logic [31:0] v);
    q.push_back('{nm, k, v});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b, input bit gap);
    if (gap) begin
      ld_valid = 1'b0;
      tick();
    end
    ld_valid = 1'b1;
    ld_data = b;
    for (int t = 0; t < 20; t++) begin
      if (ld_ready) begin
        tick();
        ld_valid = 1'b0;
        return;
      end
      tick();
    end
    ld_valid = 1'b0;
    tmo++;
    $display("FAIL send_byte: ready stayed %b, expected 1 within 20 cycles", ld_ready);
  endtask
  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask
  task automatic send_image(input bit gap);
    logic [31:0] s;
    s = '0;
    send_word(32'(img.size()), gap);
    foreach (img[i]) begin
      send_word(img[i], gap);
      s += img[i];
    end
`ifdef LOADER_CHKSUM_EN
    send_word(s, gap);
`endif
  endtask
  task automatic start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    total++;
    if (core_rst0 === 1'b0) pass++;
    else $display("FAIL bh0 direct core_rst: got %b, expected 0", core_rst0);
    expect_v("rst core_rst", K_CRST, 1);
    expect_v("rst busy", K_BUSY, 1);
    expect_v("rst done", K_DONE, 0);
    expect_v("rst err", K_ERR, 0);
    expect_v("rst ready", K_RDY, 1);
    expect_v("rst fetch nop", K_INST, NOP);
    expect_v("bh0 core_rst", K_CRST0, 0);
    expect_v("bh0 busy", K_BUSY0, 0);
    expect_v("bh0 done/err", K_ERR0, 0);
    expect_v("bh0 ready", K_RDY0, 0);
    expect_v("bh0 out of range nop", K_INST0, NOP);
    tick();
    img = '{32'h0000_0093, 32'h0010_0113};
    send_image(1'b0);
    expect_v("t1 held in REL", K_CRST, 1);
    expect_v("t1 done not yet", K_DONE, 0);
    tick();
    expect_v("t1 core released", K_CRST, 0);
    expect_v("t1 done", K_DONE, 1);
    expect_v("t1 busy low", K_BUSY, 0);
    inst_addr = 32'd4;
    expect_v("t1 fetch word1", K_INST, 32'h0010_0113);
    tick();
    inst_addr = 32'd3;
    expect_v("t1 fetch word0 low bits ignored", K_INST, 32'h0000_0093);
    tick();
    inst_addr = 32'h0001_0000;
    expect_v("t1 out of range nop", K_INST, NOP);
    tick();
    start();
    expect_v("t2 start clears done", K_DONE, 0);
    expect_v("t2 start busy", K_BUSY, 1);
    expect_v("t2 start core_rst", K_CRST, 1);
    send_word(32'd0, 1'b0);
    inst_addr = 32'd4;
    expect_v("t2 n0 err", K_ERR, 1);
    expect_v("t2 n0 core_rst", K_CRST, 1);
    expect_v("t2 n0 ready", K_RDY, 0);
    expect_v("t2 n0 busy", K_BUSY, 0);
    expect_v("t2 n0 nop", K_INST, NOP);
    tick();
    start();
    expect_v("t2 restart clears err", K_ERR, 0);
    send_word(32'(DEPTH + 1), 1'b0);
    expect_v("t2 nbig err", K_ERR, 1);
    expect_v("t2 nbig ready", K_RDY, 0);
    expect_v("t2 nbig nop", K_INST, NOP);
    tick();
    start();
    send_word(32'd2, 1'b1);
    send_word(32'h4433_2211, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_data = 8'h55;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    expect_v("t3 restart busy", K_BUSY, 1);
    expect_v("t3 restart ready", K_RDY, 1);
    img = '{32'hDEAD_BEEF};
    send_image(1'b1);
    tick();
    inst_addr = 32'd0;
    expect_v("t3 done", K_DONE, 1);
    expect_v("t3 err", K_ERR, 0);
    expect_v("t3 fetch new word", K_INST, 32'hDEAD_BEEF);
    tick();
    inst_addr = 32'd4;
    expect_v("t3 old word kept", K_INST, 32'h0010_0113);
    tick();
`ifdef LOADER_CHKSUM_EN
    start();
    send_word(32'd2, 1'b0);
    send_word(32'd1, 1'b0);
    send_word(32'd2, 1'b0);
    send_word(32'd3, 1'b0);
    tick();
    expect_v("t5 good sum done", K_DONE, 1);
    expect_v("t5 good sum err", K_ERR, 0);
    tick();
    start();
    send_word(32'd2, 1'b0);
    send_word(32'd1, 1'b0);
    send_word(32'd2, 1'b0);
    send_word(32'd4, 1'b0);
    expect_v("t5 bad sum err", K_ERR, 1);
    expect_v("t5 bad sum held", K_CRST, 1);
    expect_v("t5 bad sum done", K_DONE, 0);
    tick();
`endif
    start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_v("t6 rst core_rst", K_CRST, 1);
    expect_v("t6 rst busy", K_BUSY, 1);
    expect_v("t6 rst ready", K_RDY, 1);
    expect_v("t6 rst done", K_DONE, 0);
    img = '{32'h0000_0513};
    send_image(1'b0);
    tick();
    inst_addr = 32'd0;
    expect_v("t6 fresh done", K_DONE, 1);
    expect_v("t6 fresh core released", K_CRST, 0);
    expect_v("t6 fresh fetch", K_INST, 32'h0000_0513);
    total++;
    if (done === 1'b1) pass++;
    else $display("FAIL t6 direct done: got %b, expected 1", done);
    tick();
    tick();
    total++;
    if (tmo == 0) pass++;
    else $display("FAIL send_byte timeouts: got %0d, expected 0", tmo);
    $display("%0d/%0d checks passed", pass, total + tmo);
    $finish;
  end
endmodule
